fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 111 +++++++++++
 tb/tb_fifo_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for an OSTD_NUM-entry FIFO memory; strobes are combinational, state and flags land on the next edge.
// Push into a full FIFO is accepted only alongside a pop; a pop from an empty FIFO is always refused (no bypass).
module fifo_ctrl #(
  parameter int OSTD_NUM        = 8,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1
) (
  input  logic                clk_in,
  input  logic                sreset,
  input  logic                push_req,
  input  logic                pop_req,
  input  logic                err_clear,
  output logic                fifo_wenable,
  output logic                fifo_renable,
  output logic [OSTD_NUM-1:0] write_ptr,
  output logic [OSTD_NUM-1:0] read_ptr,
  output logic [PTR_SIZE:0]   fifo_count,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                below_threshold,
  output logic                overflow_err,
  output logic                underflow_err
);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  localparam logic [PTR_SIZE-1:0] PTR_LAST  = PTR_SIZE'(OSTD_NUM - 1);
  localparam logic [PTR_SIZE-1:0] PTR_ONE   = PTR_SIZE'(1);
  localparam logic [PTR_SIZE:0]   CNT_MAX   = (PTR_SIZE + 1)'(OSTD_NUM);
  localparam logic [PTR_SIZE:0]   CNT_ONE   = (PTR_SIZE + 1)'(1);
  localparam logic                BELOW_RST = (THRESHOLD_VALUE > 0);

  state_t              state_q, state_d;
  logic [PTR_SIZE-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_SIZE:0]   cnt_q, cnt_d;
  logic                push_acc, pop_acc, ovf_set, unf_set;

  // State register: occupancy FSM, pointers and count.
  always_ff @(posedge clk_in) begin
    if (sreset) begin
      state_q <= ST_EMPTY;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; pointers wrap explicitly so non-power-of-2 depths work.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (push_acc) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_ONE;
    if (pop_acc)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_ONE;
    if (push_acc && !pop_acc)      cnt_d = cnt_q + CNT_ONE;
    else if (pop_acc && !push_acc) cnt_d = cnt_q - CNT_ONE;
    case (state_q)
      ST_EMPTY: begin
        if (push_acc) state_d = (OSTD_NUM == 1) ? ST_FULL : ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push_acc && !pop_acc && (cnt_q == CNT_MAX - CNT_ONE)) state_d = ST_FULL;
        else if (pop_acc && !push_acc && (cnt_q == CNT_ONE))      state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop_acc && !push_acc) state_d = (OSTD_NUM == 1) ? ST_EMPTY : ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output logic: accept decisions use the registered flags, which track state_q.
  always_comb begin
    push_acc = ~sreset & push_req & (~fifo_full | pop_req);
    pop_acc  = ~sreset & pop_req & ~fifo_empty;
    ovf_set  = push_req & fifo_full & ~pop_req;
    unf_set  = pop_req & fifo_empty;
  end

  assign fifo_wenable = push_acc;
  assign fifo_renable = pop_acc;
  assign write_ptr    = OSTD_NUM'(wr_q);
  assign read_ptr     = OSTD_NUM'(rd_q);
  assign fifo_count   = cnt_q;

  // Flags are decoded from next-state/next-count so they are registered yet current.
  always_ff @(posedge clk_in) begin
    if (sreset) begin
      fifo_full       <= 1'b0;
      fifo_empty      <= 1'b1;
      below_threshold <= BELOW_RST;
      overflow_err    <= 1'b0;
      underflow_err   <= 1'b0;
    end else begin
      fifo_full       <= (state_d == ST_FULL);
      fifo_empty      <= (state_d == ST_EMPTY);
      below_threshold <= (int'(cnt_d) < THRESHOLD_VALUE);
      if (err_clear)    overflow_err  <= 1'b0;
      else if (ovf_set) overflow_err  <= 1'b1;
      if (err_clear)    underflow_err <= 1'b0;
      else if (unf_set) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl (OSTD_NUM=8, THRESHOLD_VALUE=4) with a reference data queue behind a model memory.
module tb_fifo_ctrl;

  logic       clk_in = 1'b0;
  logic       sreset = 1'b1;
  logic       push_req = 1'b0;
  logic       pop_req = 1'b0;
  logic       err_clear = 1'b0;
  logic       fifo_wenable, fifo_renable;
  logic [7:0] write_ptr, read_ptr;
  logic [3:0] fifo_count;
  logic       fifo_full, fifo_empty, below_threshold, overflow_err, underflow_err;

  fifo_ctrl #(.OSTD_NUM(8), .THRESHOLD_VALUE(4)) dut (
    .clk_in(clk_in), .sreset(sreset), .push_req(push_req), .pop_req(pop_req),
    .err_clear(err_clear), .fifo_wenable(fifo_wenable), .fifo_renable(fifo_renable),
    .write_ptr(write_ptr), .read_ptr(read_ptr), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .below_threshold(below_threshold),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic wen, ren;
    int   wp, rp, cnt;
    logic full, empty, below, ovf, unf;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] dq[$];
  logic [7:0] mem[8];
  logic [7:0] wdata = 8'h00;
  int         checks = 0;
  int         failures = 0;

  int   m_wp = 0, m_rp = 0, m_cnt = 0, dseq = 1;
  logic m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk_in) if (fifo_wenable) mem[write_ptr[2:0]] <= wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, queue the expected observation, advance the model.
  task automatic cycle(input logic rst, input logic push, input logic pop, input logic clr);
    exp_t e;
    logic wen, ren;
    @(posedge clk_in); #1;
    sreset = rst; push_req = push; pop_req = pop; err_clear = clr; wdata = 8'(dseq);
    wen = !rst && push && (m_cnt < 8 || pop);
    ren = !rst && pop && (m_cnt > 0);
    e.wen = wen; e.ren = ren; e.wp = m_wp; e.rp = m_rp; e.cnt = m_cnt;
    e.full = (m_cnt == 8); e.empty = (m_cnt == 0); e.below = (m_cnt < 4);
    e.ovf = m_ovf; e.unf = m_unf;
    expq.push_back(e);
    if (wen) dq.push_back(8'(dseq));
    dseq++;
    if (rst) begin
      m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      dq.delete();
    end else begin
      if (clr) m_ovf = 1'b0; else if (push && m_cnt == 8 && !pop) m_ovf = 1'b1;
      if (clr) m_unf = 1'b0; else if (pop && m_cnt == 0) m_unf = 1'b1;
      if (wen) m_wp = (m_wp + 1) % 8;
      if (ren) m_rp = (m_rp + 1) % 8;
      m_cnt = m_cnt + int'(wen) - int'(ren);
    end
  endtask

  // Monitor: every cycle the DUT presents its strobes and state; compare against the queue head.
  initial begin
    exp_t e;
    logic [7:0] ref_d;
    forever begin
      @(negedge clk_in);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("wenable",   32'(fifo_wenable),    32'(e.wen));
        check("renable",   32'(fifo_renable),    32'(e.ren));
        check("write_ptr", 32'(write_ptr),       32'(e.wp));
        check("read_ptr",  32'(read_ptr),        32'(e.rp));
        check("count",     32'(fifo_count),      32'(e.cnt));
        check("full",      32'(fifo_full),       32'(e.full));
        check("empty",     32'(fifo_empty),      32'(e.empty));
        check("below",     32'(below_threshold), 32'(e.below));
        check("overflow",  32'(overflow_err),    32'(e.ovf));
        check("underflow", 32'(underflow_err),   32'(e.unf));
        if (fifo_renable === 1'b1) begin
          if (dq.size() == 0) begin
            check("read_data_present", 32'(0), 32'(1));
          end else begin
            ref_d = dq.pop_front();
            check("read_data", 32'(mem[read_ptr[2:0]]), 32'(ref_d));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle(1, 0, 0, 0);                                   // reset state
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);       // fill to 8
    cycle(0, 1, 0, 1);                                   // overflow set vs clear: clear wins
    cycle(0, 1, 0, 0);                                   // overflow, rejected push
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);                                   // clear overflow
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);                                   // full: push+pop both accepted
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);       // drain
    cycle(0, 0, 1, 0);                                   // underflow
    cycle(0, 0, 0, 1);
    cycle(0, 1, 1, 0);                                   // empty: push only, underflow sets
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 20; i++)                         // interleaved wrap traffic
      cycle(0, (i % 4) != 3, (i % 2) == 1, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, (i % 3) == 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, i < 6, 1, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);       // count 5
    cycle(1, 1, 0, 0);                                   // reset with push high
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk_in); #1;
    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk_in);
    check("scoreboard_drained", 32'(expq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
